// File: rtl/simmem_rburst_limiter.sv
// simmem_rburst_limiter
//   Read-address admission limiter placed in front of the simulated memory
//   controller. Caps outstanding read bursts per AXI ID and in total, tracks
//   read-data beats against each burst's recorded length, frees a slot on the
//   last beat and generates the per-beat last flag.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   raddr_in_valid_i/ready_o   requester side of the read-address channel
//   raddr_id_i, raddr_burst_len_i  ID and AXI len of the offered address
//   raddr_out_valid_o/ready_i  controller side of the read-address channel
//   rdata_hs_i, rdata_id_i     observed read-data beat handshake and its ID
//   rdata_last_o           combinational: current beat closes its burst
//   outstanding_total_o    bursts currently outstanding across all IDs
//   err_unexpected_o       sticky: beat seen for an ID with nothing outstanding
module simmem_rburst_limiter #(
    parameter int unsigned NumIds    = 4,
    parameter int unsigned IdW       = 2,
    parameter int unsigned BurstLenW = 4,
    parameter int unsigned MaxPerId  = 4,
    parameter int unsigned MaxTotal  = 8,
    localparam int unsigned TotW     = $clog2(MaxTotal + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 raddr_in_valid_i,
    output logic                 raddr_in_ready_o,
    input  logic [IdW-1:0]       raddr_id_i,
    input  logic [BurstLenW-1:0] raddr_burst_len_i,
    output logic                 raddr_out_valid_o,
    input  logic                 raddr_out_ready_i,
    input  logic                 rdata_hs_i,
    input  logic [IdW-1:0]       rdata_id_i,
    output logic                 rdata_last_o,
    output logic [TotW-1:0]      outstanding_total_o,
    output logic                 err_unexpected_o
);

    localparam int unsigned PtrW = (MaxPerId > 1) ? $clog2(MaxPerId) : 1;
    localparam int unsigned CntW = $clog2(MaxPerId + 1);

    logic [CntW-1:0]      cnt_q     [NumIds];
    logic [BurstLenW-1:0] beat_q    [NumIds];
    logic [PtrW-1:0]      wptr_q    [NumIds];
    logic [PtrW-1:0]      rptr_q    [NumIds];
    logic [BurstLenW-1:0] len_mem_q [NumIds][MaxPerId];
    logic [TotW-1:0]      total_q;
    logic                 err_q;

    logic                 allow;
    logic                 accept;
    logic                 rd_busy;
    logic                 rd_last;
    logic                 rd_beat;
    logic                 rd_unexp;
    logic [BurstLenW-1:0] rd_head;
    logic [NumIds-1:0]    push_vec;
    logic [NumIds-1:0]    pop_vec;
    logic [NumIds-1:0]    beat_vec;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxPerId - 1)) ? '0 : p + 1'b1;
    endfunction

    // Admission looks only at registered counts, so a slot freed by a last
    // beat becomes usable one cycle later (no rdata -> raddr path).
    always_comb begin
        allow    = (cnt_q[raddr_id_i] < CntW'(MaxPerId)) && (total_q < TotW'(MaxTotal));
        accept   = raddr_in_valid_i && raddr_out_ready_i && allow;
        rd_busy  = (cnt_q[rdata_id_i] != '0);
        rd_head  = len_mem_q[rdata_id_i][rptr_q[rdata_id_i]];
        rd_last  = rdata_hs_i && rd_busy && (beat_q[rdata_id_i] == rd_head);
        rd_beat  = rdata_hs_i && rd_busy && !rd_last;
        rd_unexp = rdata_hs_i && !rd_busy;
        push_vec = '0;
        pop_vec  = '0;
        beat_vec = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            push_vec[i] = accept  && (raddr_id_i == IdW'(i));
            pop_vec[i]  = rd_last && (rdata_id_i == IdW'(i));
            beat_vec[i] = rd_beat && (rdata_id_i == IdW'(i));
        end
    end

    assign raddr_out_valid_o   = raddr_in_valid_i && allow;
    assign raddr_in_ready_o    = raddr_out_ready_i && allow;
    assign rdata_last_o        = rd_last;
    assign outstanding_total_o = total_q;
    assign err_unexpected_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                cnt_q[i]  <= '0;
                beat_q[i] <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                if (push_vec[i]) begin
                    wptr_q[i] <= ptr_inc(wptr_q[i]);
                end
                if (pop_vec[i]) begin
                    rptr_q[i] <= ptr_inc(rptr_q[i]);
                    beat_q[i] <= '0;
                end else if (beat_vec[i]) begin
                    beat_q[i] <= beat_q[i] + 1'b1;
                end
                // Push and pop on the same ID cancel out.
                if (push_vec[i] && !pop_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (pop_vec[i] && !push_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
            if (accept && !rd_last) begin
                total_q <= total_q + 1'b1;
            end else if (rd_last && !accept) begin
                total_q <= total_q - 1'b1;
            end
            if (rd_unexp) begin
                err_q <= 1'b1;
            end
        end
    end

    // Length storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            if (push_vec[i]) begin
                len_mem_q[i][wptr_q[i]] <= raddr_burst_len_i;
            end
        end
    end

endmodule

// File: tb/tb_simmem_rburst_limiter.sv
// Testbench for simmem_rburst_limiter: directed scenarios followed by random
// traffic, checked against a queue-based reference model via a scoreboard.
module tb_simmem_rburst_limiter;

    localparam int unsigned NumIds    = 4;
    localparam int unsigned IdW       = 2;
    localparam int unsigned BurstLenW = 4;
    localparam int unsigned MaxPerId  = 4;
    localparam int unsigned MaxTotal  = 8;
    localparam int unsigned TotW      = $clog2(MaxTotal + 1);

    logic                 clk_i;
    logic                 rst_ni;
    logic                 raddr_in_valid_i;
    logic                 raddr_in_ready_o;
    logic [IdW-1:0]       raddr_id_i;
    logic [BurstLenW-1:0] raddr_burst_len_i;
    logic                 raddr_out_valid_o;
    logic                 raddr_out_ready_i;
    logic                 rdata_hs_i;
    logic [IdW-1:0]       rdata_id_i;
    logic                 rdata_last_o;
    logic [TotW-1:0]      outstanding_total_o;
    logic                 err_unexpected_o;

    simmem_rburst_limiter #(
        .NumIds   (NumIds),
        .IdW      (IdW),
        .BurstLenW(BurstLenW),
        .MaxPerId (MaxPerId),
        .MaxTotal (MaxTotal)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .raddr_in_valid_i   (raddr_in_valid_i),
        .raddr_in_ready_o   (raddr_in_ready_o),
        .raddr_id_i         (raddr_id_i),
        .raddr_burst_len_i  (raddr_burst_len_i),
        .raddr_out_valid_o  (raddr_out_valid_o),
        .raddr_out_ready_i  (raddr_out_ready_i),
        .rdata_hs_i         (rdata_hs_i),
        .rdata_id_i         (rdata_id_i),
        .rdata_last_o       (rdata_last_o),
        .outstanding_total_o(outstanding_total_o),
        .err_unexpected_o   (err_unexpected_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic ready;
        logic valid;
        logic last;
        int   total;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference model: one queue of burst lengths per ID, beats seen on the
    // head burst, sticky error flag.
    int   m_len[NumIds][$];
    int   m_seen[NumIds];
    bit   m_err;

    function automatic int m_total();
        int t = 0;
        for (int i = 0; i < NumIds; i++) t += m_len[i].size();
        return t;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NumIds; i++) begin
            m_len[i].delete();
            m_seen[i] = 0;
        end
        m_err = 0;
    endtask

    // Apply one cycle of inputs, record the expected outputs for that cycle,
    // advance the model, then move to just after the next rising edge.
    task automatic step(input bit rst, input bit v, input int id, input int len,
                        input bit ordy, input bit hs, input int rid);
        exp_t e;
        bit   allow, acc, busy, last;
        rst_ni            = ~rst;
        raddr_in_valid_i  = v;
        raddr_id_i        = IdW'(id);
        raddr_burst_len_i = BurstLenW'(len);
        raddr_out_ready_i = ordy;
        rdata_hs_i        = hs;
        rdata_id_i        = IdW'(rid);

        allow = (m_len[id].size() < MaxPerId) && (m_total() < MaxTotal);
        acc   = v && ordy && allow;
        busy  = m_len[rid].size() > 0;
        last  = hs && busy && (m_seen[rid] == m_len[rid][0]);
        e.ready = ordy && allow;
        e.valid = v && allow;
        e.last  = last;
        e.total = m_total();
        e.err   = m_err;
        exp_q.push_back(e);

        if (rst) begin
            m_clear();
        end else begin
            if (hs && !busy) m_err = 1;
            else if (last) begin
                void'(m_len[rid].pop_front());
                m_seen[rid] = 0;
            end else if (hs) m_seen[rid]++;
            if (acc) m_len[id].push_back(len);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic addr(input int id, input int len);
        step(0, 1, id, len, 1, 0, 0);
    endtask

    task automatic beat(input int rid);
        step(0, 0, 0, 0, 1, 1, rid);
    endtask

    // Monitor: compares every recorded cycle at the falling edge.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (raddr_in_ready_o !== e.ready) begin
                errors++;
                $display("FAIL in_ready got %b want %b t=%0t", raddr_in_ready_o, e.ready, $time);
            end
            checks++;
            if (raddr_out_valid_o !== e.valid) begin
                errors++;
                $display("FAIL out_valid got %b want %b t=%0t", raddr_out_valid_o, e.valid, $time);
            end
            checks++;
            if (rdata_last_o !== e.last) begin
                errors++;
                $display("FAIL rdata_last got %b want %b t=%0t", rdata_last_o, e.last, $time);
            end
            checks++;
            if (outstanding_total_o !== TotW'(e.total)) begin
                errors++;
                $display("FAIL total got %0d want %0d t=%0t", outstanding_total_o, e.total, $time);
            end
            checks++;
            if (err_unexpected_o !== e.err) begin
                errors++;
                $display("FAIL err_unexpected got %b want %b t=%0t", err_unexpected_o, e.err, $time);
            end
        end
    end

    initial begin
        rst_ni = 0; raddr_in_valid_i = 0; raddr_id_i = '0; raddr_burst_len_i = '0;
        raddr_out_ready_i = 0; rdata_hs_i = 0; rdata_id_i = '0;
        m_clear();
        @(posedge clk_i);
        #1;
        // Reset state, then open admission with a valid offer.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);

        // Single burst: id 1, len 3, four beats.
        addr(1, 3);
        for (int k = 0; k < 4; k++) beat(1);
        idle(1);

        // Per-ID cap on id 2, then free one burst while the 5th waits.
        for (int k = 0; k < 5; k++) addr(2, 1);
        step(0, 1, 2, 1, 1, 1, 2);
        step(0, 1, 2, 1, 1, 1, 2);
        step(0, 1, 2, 1, 1, 0, 0);
        for (int k = 0; k < 8; k++) beat(2);
        idle(1);

        // Total cap: two single-beat bursts per ID, then id 0 offered.
        for (int i = 0; i < 4; i++) begin
            addr(i, 0);
            addr(i, 0);
        end
        addr(0, 0);
        for (int i = 0; i < 4; i++) begin
            beat(i);
            beat(i);
        end
        idle(1);

        // Last beat and offer on the same full ID in one cycle.
        for (int k = 0; k < 4; k++) addr(0, 0);
        step(0, 1, 0, 5, 1, 1, 0);
        step(0, 1, 0, 5, 1, 0, 0);
        idle(1);
        beat(0); beat(0); beat(0);
        for (int k = 0; k < 6; k++) beat(0);
        idle(1);

        // Interleave with a single-beat burst.
        addr(0, 0);
        addr(1, 1);
        beat(1); beat(0); beat(1);
        idle(1);

        // Unexpected beat, sticky error, reset clears it.
        beat(3);
        idle(3);
        addr(2, 2);
        step(1, 0, 0, 0, 1, 0, 0);
        idle(1);
        beat(2);
        step(1, 0, 0, 0, 1, 0, 0);
        idle(1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit v, ordy, hs, rst;
            int id, len, rid;
            v    = ($urandom_range(0, 3) != 0);
            id   = $urandom_range(0, NumIds - 1);
            len  = $urandom_range(0, 3);
            ordy = ($urandom_range(0, 3) != 0);
            rid  = $urandom_range(0, NumIds - 1);
            hs   = ($urandom_range(0, 1) == 1);
            if (hs && m_len[rid].size() == 0 && $urandom_range(0, 19) != 0) hs = 0;
            rst  = ($urandom_range(0, 499) == 0);
            step(rst, v, id, len, ordy, hs, rid);
        end
        idle(2);
        done = 1;
    end

    initial begin
        fork
            begin
                wait (done);
                @(negedge clk_i);
                #1;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL scoreboard_drain got %0d want 0", exp_q.size());
                end
            end
            begin
                #500000;
                errors++;
                $display("FAIL timeout got running want done");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
